// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment constants and decoder state type.
// Segment words are {dp,g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  // dp position within a [0:7] segment word
  localparam int DP_IDX = 0;

  localparam logic [3:0] NIB_BAD = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    DONE
  } state_t;

endpackage

// File: rtl/seg7_lut.sv
// seg7_lut: segment pattern (dp masked high) to BCD nibble.
// Unknown patterns give NIB_BAD with valid low.
module seg7_lut
  import seg7_pkg::*;
(
  input  logic [7:0] pat,
  output logic       valid,
  output logic [3:0] nib
);

  // inverse of the BCD-to-segment table
  always_comb begin
    valid = 1'b1;
    nib   = NIB_BAD;
    case (pat)
      SEG_0:   nib = 4'd0;
      SEG_1:   nib = 4'd1;
      SEG_2:   nib = 4'd2;
      SEG_3:   nib = 4'd3;
      SEG_4:   nib = 4'd4;
      SEG_5:   nib = 4'd5;
      SEG_6:   nib = 4'd6;
      SEG_7:   nib = 4'd7;
      SEG_8:   nib = 4'd8;
      SEG_9:   nib = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_decoder.sv
// seg7_decoder: accumulates decoded 7-segment digits into
// DIGITS-wide BCD words with dp flags and error tracking.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic                CLR,
  input  logic [0:7]          SEG_IN,
  input  logic                SEG_VALID,
  output logic                READY,
  output logic [4*DIGITS-1:0] BCD_OUT,
  output logic [DIGITS-1:0]   DP_OUT,
  output logic                WORD_VALID,
  output logic                WORD_ERR,
  output logic                ERR,
  output logic [CW-1:0]       DIGIT_CNT
);

  state_t              state;
  logic [0:7]          seg_q;
  logic [4*DIGITS-1:0] acc;
  logic [DIGITS-1:0]   dp_acc;
  logic                werr;

  logic [7:0]          pat;
  logic                lut_ok;
  logic [3:0]          nib;
  logic                bad;
  logic [4*DIGITS-1:0] acc_n;
  logic [DIGITS-1:0]   dp_n;
  logic                werr_n;
  logic                last;

  assign pat = {1'b1, seg_q[1:7]};

  seg7_lut u_lut (
    .pat   (pat),
    .valid (lut_ok),
    .nib   (nib)
  );

  assign bad   = ~lut_ok;
  assign READY = EN & (state == IDLE);
  assign last  = (DIGIT_CNT == CW'(DIGITS - 1));

  // next accumulator values: newest digit enters at the LSB end
  always_comb begin
    acc_n       = acc << 4;
    acc_n[3:0]  = nib;
    dp_n        = dp_acc << 1;
    dp_n[0]     = ~seg_q[DP_IDX];
    werr_n      = werr | bad;
  end

  // capture / decode / present sequencer with registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      seg_q      <= '0;
      acc        <= '0;
      dp_acc     <= '0;
      werr       <= 1'b0;
      BCD_OUT    <= '0;
      DP_OUT     <= '0;
      WORD_VALID <= 1'b0;
      WORD_ERR   <= 1'b0;
      ERR        <= 1'b0;
      DIGIT_CNT  <= '0;
    end else if (CLR) begin
      state      <= IDLE;
      acc        <= '0;
      dp_acc     <= '0;
      werr       <= 1'b0;
      BCD_OUT    <= '0;
      DP_OUT     <= '0;
      WORD_VALID <= 1'b0;
      WORD_ERR   <= 1'b0;
      ERR        <= 1'b0;
      DIGIT_CNT  <= '0;
    end else if (EN) begin
      case (state)
        IDLE: begin
          if (SEG_VALID) begin
            seg_q <= SEG_IN;
            state <= DECODE;
          end
        end
        DECODE: begin
          acc    <= acc_n;
          dp_acc <= dp_n;
          werr   <= werr_n;
          ERR    <= ERR | bad;
          if (last) begin
            BCD_OUT    <= acc_n;
            DP_OUT     <= dp_n;
            WORD_ERR   <= werr_n;
            WORD_VALID <= 1'b1;
            DIGIT_CNT  <= '0;
            state      <= DONE;
          end else begin
            DIGIT_CNT <= DIGIT_CNT + CW'(1);
            state     <= IDLE;
          end
        end
        DONE: begin
          WORD_VALID <= 1'b0;
          acc        <= '0;
          dp_acc     <= '0;
          werr       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_decoder.sv
// tb_seg7_decoder: directed tests for seg7_decoder (DIGITS=4).
// Inputs change and outputs are sampled 1ns after rising edges.
module tb_seg7_decoder;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EN = 1'b0;
  logic        CLR = 1'b0;
  logic [0:7]  SEG_IN = '1;
  logic        SEG_VALID = 1'b0;
  logic        READY;
  logic [15:0] BCD_OUT;
  logic [3:0]  DP_OUT;
  logic        WORD_VALID;
  logic        WORD_ERR;
  logic        ERR;
  logic [1:0]  DIGIT_CNT;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_cap = 0;

  seg7_decoder #(.DIGITS(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .CLR        (CLR),
    .SEG_IN     (SEG_IN),
    .SEG_VALID  (SEG_VALID),
    .READY      (READY),
    .BCD_OUT    (BCD_OUT),
    .DP_OUT     (DP_OUT),
    .WORD_VALID (WORD_VALID),
    .WORD_ERR   (WORD_ERR),
    .ERR        (ERR),
    .DIGIT_CNT  (DIGIT_CNT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // wait (bounded) for READY, present one pattern, capture it
  task automatic send(input logic [7:0] p);
    int n;
    n = 0;
    while (!READY && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: READY=%b required 1", READY);
    end
    SEG_IN = p;
    SEG_VALID = 1'b1;
    tick();
    SEG_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    EN = 1'b0;
    #3;
    checks++;
    if ({READY, BCD_OUT, DP_OUT, WORD_VALID, WORD_ERR, ERR, DIGIT_CNT}
        !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got bcd=%h dp=%b wv=%b rdy=%b",
               BCD_OUT, DP_OUT, WORD_VALID, READY);
    end
    tick();
    RST_N = 1'b1;
    tick();
    checks++;
    if (READY !== 1'b0) begin
      errors++;
      $display("FAIL ready_en_low: got %b required 0", READY);
    end
    EN = 1'b1;
    #1;
    checks++;
    if (READY !== 1'b1) begin
      errors++;
      $display("FAIL ready_en_high: got %b required 1", READY);
    end
  endtask

  task automatic test_word();
    send(8'hA4);
    first_cap = cyc;
    send(8'hB0);
    send(8'h99);
    send(8'h92);
    checks++;
    if (WORD_VALID !== 1'b0) begin
      errors++;
      $display("FAIL word_early: WORD_VALID=%b required 0", WORD_VALID);
    end
    tick();
    checks++;
    if (WORD_VALID !== 1'b1 || cyc - first_cap != 7) begin
      errors++;
      $display("FAIL word_latency: wv=%b edges=%0d required 1,7",
               WORD_VALID, cyc - first_cap);
    end
    checks++;
    if (BCD_OUT !== 16'h2345 || WORD_ERR !== 1'b0 || DP_OUT !== 4'b0) begin
      errors++;
      $display("FAIL word_data: bcd=%h err=%b dp=%b required 2345,0,0000",
               BCD_OUT, WORD_ERR, DP_OUT);
    end
    tick();
    checks++;
    if (WORD_VALID !== 1'b0 || READY !== 1'b1) begin
      errors++;
      $display("FAIL word_strobe_end: wv=%b rdy=%b required 0,1",
               WORD_VALID, READY);
    end
  endtask

  task automatic test_invalid();
    send(8'hF9);
    send(8'hFF);
    send(8'hB0);
    send(8'h99);
    tick();
    checks++;
    if (BCD_OUT !== 16'h1F34 || WORD_ERR !== 1'b1 || ERR !== 1'b1) begin
      errors++;
      $display("FAIL invalid_word: bcd=%h werr=%b err=%b required 1f34,1,1",
               BCD_OUT, WORD_ERR, ERR);
    end
    send(8'hC0);
    send(8'hF9);
    send(8'hA4);
    send(8'hB0);
    tick();
    checks++;
    if (BCD_OUT !== 16'h0123 || WORD_ERR !== 1'b0 || ERR !== 1'b1) begin
      errors++;
      $display("FAIL clean_after_bad: bcd=%h werr=%b err=%b required 0123,0,1",
               BCD_OUT, WORD_ERR, ERR);
    end
  endtask

  task automatic test_reset_mid();
    send(8'h82);
    send(8'hF8);
    tick();
    checks++;
    if (DIGIT_CNT !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset_cnt: got %0d required 2", DIGIT_CNT);
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({BCD_OUT, DP_OUT, WORD_VALID, WORD_ERR, ERR, DIGIT_CNT} !== 26'd0)
    begin
      errors++;
      $display("FAIL mid_reset: bcd=%h err=%b cnt=%0d required 0",
               BCD_OUT, ERR, DIGIT_CNT);
    end
    tick();
    RST_N = 1'b1;
    tick();
    checks++;
    if (READY !== EN) begin
      errors++;
      $display("FAIL ready_after_reset: got %b required %b", READY, EN);
    end
    send(8'h90);
    send(8'h80);
    send(8'hF8);
    send(8'h82);
    tick();
    checks++;
    if (BCD_OUT !== 16'h9876 || WORD_VALID !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_word: bcd=%h wv=%b required 9876,1",
               BCD_OUT, WORD_VALID);
    end
  endtask

  task automatic test_dp();
    send(8'h40);
    send(8'h00);
    send(8'hC0);
    send(8'hC0);
    tick();
    checks++;
    if (BCD_OUT !== 16'h0800 || DP_OUT !== 4'b1100 || WORD_ERR !== 1'b0)
    begin
      errors++;
      $display("FAIL dp_word: bcd=%h dp=%b werr=%b required 0800,1100,0",
               BCD_OUT, DP_OUT, WORD_ERR);
    end
  endtask

  task automatic test_en_hold();
    send(8'hA4);
    EN = 1'b0;
    SEG_IN = 8'hF9;
    SEG_VALID = 1'b1;
    repeat (3) tick();
    checks++;
    if (READY !== 1'b0 || DIGIT_CNT !== 2'd0 || BCD_OUT !== 16'h0800) begin
      errors++;
      $display("FAIL en_hold_decode: rdy=%b cnt=%0d bcd=%h required 0,0,0800",
               READY, DIGIT_CNT, BCD_OUT);
    end
    SEG_VALID = 1'b0;
    EN = 1'b1;
    tick();
    checks++;
    if (DIGIT_CNT !== 2'd1) begin
      errors++;
      $display("FAIL en_resume: cnt=%0d required 1", DIGIT_CNT);
    end
    send(8'hB0);
    send(8'h99);
    send(8'h92);
    tick();
    EN = 1'b0;
    repeat (3) tick();
    checks++;
    if (WORD_VALID !== 1'b1 || BCD_OUT !== 16'h2345 || READY !== 1'b0) begin
      errors++;
      $display("FAIL en_hold_wv: wv=%b bcd=%h rdy=%b required 1,2345,0",
               WORD_VALID, BCD_OUT, READY);
    end
    EN = 1'b1;
    tick();
    checks++;
    if (WORD_VALID !== 1'b0) begin
      errors++;
      $display("FAIL en_wv_one_cycle: wv=%b required 0", WORD_VALID);
    end
  endtask

  task automatic test_clr();
    send(8'hFF);
    send(8'hF9);
    tick();
    checks++;
    if (ERR !== 1'b1 || DIGIT_CNT !== 2'd2) begin
      errors++;
      $display("FAIL pre_clr: err=%b cnt=%0d required 1,2", ERR, DIGIT_CNT);
    end
    EN = 1'b0;
    CLR = 1'b1;
    tick();
    checks++;
    if ({BCD_OUT, DP_OUT, WORD_VALID, WORD_ERR, ERR, DIGIT_CNT} !== 26'd0)
    begin
      errors++;
      $display("FAIL clr_outputs: bcd=%h err=%b cnt=%0d required 0",
               BCD_OUT, ERR, DIGIT_CNT);
    end
    CLR = 1'b0;
    EN = 1'b1;
    send(8'h99);
    send(8'h92);
    send(8'h82);
    send(8'hF8);
    tick();
    checks++;
    if (BCD_OUT !== 16'h4567 || WORD_ERR !== 1'b0 || ERR !== 1'b0) begin
      errors++;
      $display("FAIL clr_fresh_word: bcd=%h werr=%b err=%b required 4567,0,0",
               BCD_OUT, WORD_ERR, ERR);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_invalid();
    test_reset_mid();
    test_dp();
    test_en_hold();
    test_clr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
